sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
- Controller that sequences a WIDTH-bit serial-in/parallel-out shift path.
- Frames serial bits after a start strobe and counts them in.
- Transfers each completed word to an output holding register with a valid/ready handshake.
- Flags overruns; sits between a serial bit source and a parallel word consumer.

Parameters:
- WIDTH, 4, bits per word, legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a new frame (single-cycle strobe).
- sin  in  1  serial data bit.
- sin_vld  in  1  sin is valid this cycle.
- word  out  WIDTH  assembled parallel word.
- word_vld  out  1  word holds an unconsumed result.
- word_rdy  in  1  consumer accepts word when word_vld is high.
- busy  out  1  frame in progress (state != IDLE).
- bit_cnt  out  CNT_W  bits received in the current frame.
- overrun  out  1  sticky: completed word dropped because the holding register was full.
- par_err  out  1  sticky parity error; tied 0 without PARITY_CHK_EN.
- clr_err  in  1  clear the sticky flags.

Behaviour:
- Reset (async, immediate): state=IDLE; bit_cnt=0; shift reg=0; word=0; word_vld=0; overrun=0; par_err=0.
- States: IDLE, SHIFT, plus PAR when PARITY_CHK_EN is defined.
- IDLE:
  - start=1 -> SHIFT, bit_cnt=0, shift reg=0.
  - sin_vld is ignored in IDLE, including the start cycle.
- SHIFT, each sin_vld=1 cycle:
  - shift reg <= {sin, sr[WIDTH-1:1]}; bit_cnt++.
  - The first bit received ends in word[0], the last in word[WIDTH-1].
- Word completion (bit_cnt reaches WIDTH on a sampled sin_vld): attempt to load the holding register, then -> IDLE.
  - Load succeeds if word_vld=0, or if word_vld=1 and word_rdy=1 in the same cycle.
  - On success, word and word_vld=1 are visible the cycle after the last bit was sampled (latency 1).
  - If the register is full and not being accepted: the new word is discarded, the old word and word_vld are kept, and overrun is set.
- Restart: start=1 while in SHIFT (or PAR) discards the partial frame and sets bit_cnt=0; state stays SHIFT. start takes priority over a same-cycle sin_vld.
- Handshake:
  - word is stable while word_vld=1.
  - word_vld falls the cycle after word_rdy=1 is sampled, unless a new word loads in the same cycle (word_vld stays 1).
  - word_rdy while word_vld=0 has no effect.
- Sticky flags: clr_err=1 clears overrun and par_err. If a set event occurs in the same cycle, set wins.
- bit_cnt is 0 in IDLE and never exceeds WIDTH.
- sin_vld gaps of any length within a frame are allowed; there is no timeout.

Optional Feature:
- Macro: SIPO_PARITY_CHK_EN.
- Defined:
  - After WIDTH data bits the FSM enters PAR and waits for one more sin_vld, the even-parity bit.
  - Parity = XOR of the WIDTH data bits and the parity bit; must be 0.
  - Pass: load attempted as above, 1 cycle after the parity bit.
  - Fail: word discarded, par_err set, no overrun evaluation.
  - Return to IDLE either way.
  - start in PAR restarts as in SHIFT.
- Not defined: no PAR state, par_err constant 0, completion on the WIDTH-th bit.

Test Plan:
- Reset, then start, sin=1,0,1,1 with sin_vld each cycle, word_rdy=0 -> word=4'hD, word_vld=1 one cycle after the 4th bit, busy=0, bit_cnt=0.
- Word 4'hD pending, second frame 0,1,0,0, word_rdy=0 -> overrun=1, word stays 4'hD. Pulse clr_err -> overrun=0.
- Word pending, word_rdy=1 on the exact cycle the next frame completes (bits 1,1,1,1) -> word=4'hF, word_vld stays 1, overrun=0.
- start, bits 1,1, start again, bits 0,0,0,1 -> word=4'h8, bit_cnt never exceeds 4. Stall sin_vld 5 cycles mid-frame -> result unchanged.
- Assert rst mid-frame after 2 bits with word_vld=1 -> all outputs 0 immediately, without a clock edge. A new frame 1,0,0,0 -> 4'h1.
- SIPO_PARITY_CHK_EN: bits 1,0,1,1 + parity 1 -> word=4'hD; bits 1,0,1,1 + parity 0 -> no word_vld, par_err=1.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Frame controller for a WIDTH-bit serial-in/parallel-out path: LSB-first word assembly,
// valid/ready holding register and sticky overrun flag. Define SIPO_PARITY_CHK_EN for an even-parity bit per frame.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [WIDTH-1:0] word,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             par_err,
  input  logic             clr_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef SIPO_PARITY_CHK_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] sr_reg, sr_next, sr_shift;
  logic [WIDTH-1:0] word_reg, word_next, done_word;
  logic             word_vld_reg, word_vld_next;
  logic             overrun_reg, overrun_next;
  logic             done, load_ok;

  // New bits enter at the top so the first bit ends up in bit 0.
  assign sr_shift[WIDTH-1] = sin;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign sr_shift[gi] = sr_reg[gi+1];
    end
  endgenerate

`ifdef SIPO_PARITY_CHK_EN
  logic par_fail;
  logic par_err_reg, par_err_next;
`endif

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    sr_next      = sr_reg;
    done         = 1'b0;
    done_word    = sr_shift;
`ifdef SIPO_PARITY_CHK_EN
    par_fail     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          sr_next      = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          bit_cnt_next = '0;
          sr_next      = '0;
        end else if (sin_vld) begin
          sr_next = sr_shift;
          if (bit_cnt_reg == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHK_EN
            state_next   = PAR;
            bit_cnt_next = CNT_W'(WIDTH);
`else
            done         = 1'b1;
            state_next   = IDLE;
            bit_cnt_next = '0;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
`ifdef SIPO_PARITY_CHK_EN
      PAR: begin
        done_word = sr_reg;
        if (start) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          sr_next      = '0;
        end else if (sin_vld) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          if ((^sr_reg) ^ sin) par_fail = 1'b1;
          else                 done     = 1'b1;
        end
      end
`endif
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  // A completed word may replace the held one only if that one is leaving this cycle.
  always_comb begin
    load_ok       = !word_vld_reg || word_rdy;
    word_next     = word_reg;
    word_vld_next = word_vld_reg;
    if (done && load_ok) begin
      word_next     = done_word;
      word_vld_next = 1'b1;
    end else if (word_vld_reg && word_rdy) begin
      word_vld_next = 1'b0;
    end
    overrun_next = (done && !load_ok) || (overrun_reg && !clr_err);
`ifdef SIPO_PARITY_CHK_EN
    par_err_next = par_fail || (par_err_reg && !clr_err);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      sr_reg       <= '0;
      word_reg     <= '0;
      word_vld_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      sr_reg       <= sr_next;
      word_reg     <= word_next;
      word_vld_reg <= word_vld_next;
      overrun_reg  <= overrun_next;
    end
  end

`ifdef SIPO_PARITY_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_reg <= 1'b0;
    else     par_err_reg <= par_err_next;
  end
  assign par_err = par_err_reg;
`else
  assign par_err = 1'b0;
`endif

  assign word     = word_reg;
  assign word_vld = word_vld_reg;
  assign busy     = (state_reg != IDLE);
  assign bit_cnt  = bit_cnt_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl (WIDTH=4); the parity scenario runs when SIPO_PARITY_CHK_EN is defined.
module tb_sipo_frame_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst, start, sin, sin_vld, word_rdy, clr_err;
  logic [WIDTH-1:0] word;
  logic             word_vld, busy, overrun, par_err;
  logic [CNT_W-1:0] bit_cnt;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_w;

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_vld(sin_vld),
    .word(word), .word_vld(word_vld), .word_rdy(word_rdy), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun), .par_err(par_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b; sin_vld = 1'b1;
    step();
    sin_vld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Pops the head of the scoreboard, compares it against the held word, then accepts it.
  task automatic consume(input string name);
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    checks++;
    if (word_vld !== 1'b1 || word !== exp_w) begin
      errors++;
      $display("FAIL %s: word_vld=%b word=%h, required word_vld=1 word=%h", name, word_vld, word, exp_w);
    end else $display("consume %s: word=%h", name, word);
    word_rdy = 1'b1;
    step();
    word_rdy = 1'b0;
    checks++;
    if (word_vld !== 1'b0) begin
      errors++; $display("FAIL %s_drop: word_vld=%b, required 0", name, word_vld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; sin = 0; sin_vld = 0; word_rdy = 0; clr_err = 0;
    #12;
    checks++;
    if ({word, word_vld, busy, bit_cnt, overrun, par_err} !== '0) begin
      errors++;
      $display("FAIL reset: word=%h vld=%b busy=%b cnt=%0d ovr=%b perr=%b, required all 0",
               word, word_vld, busy, bit_cnt, overrun, par_err);
    end else $display("reset: outputs cleared");
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_idle_ignore();
    sin = 1'b1; sin_vld = 1'b1; word_rdy = 1'b1;
    repeat (3) step();
    word_rdy = 1'b0;
    checks++;
    if (busy !== 1'b0 || bit_cnt !== 3'd0 || word_vld !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: busy=%b cnt=%0d vld=%b, required 0 0 0", busy, bit_cnt, word_vld);
    end else $display("idle: sin_vld ignored");
    start = 1'b1;
    step();
    start = 1'b0; sin_vld = 1'b0;
    checks++;
    if (busy !== 1'b1 || bit_cnt !== 3'd0) begin
      errors++; $display("FAIL start_cycle: busy=%b cnt=%0d, required 1 0", busy, bit_cnt);
    end
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    bits = 4'b1101;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i]);
      if (i < 3) begin
        checks++;
        if (bit_cnt !== 3'(i + 1) || busy !== 1'b1 || word_vld !== 1'b0) begin
          errors++; $display("FAIL basic_cnt%0d: cnt=%0d busy=%b vld=%b, required %0d 1 0", i, bit_cnt, busy, word_vld, i + 1);
        end
      end
    end
    sb_q.push_back(4'hD);
    checks++;
    if (word_vld !== 1'b1 || word !== sb_q[0] || busy !== 1'b0 || bit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL basic_word: word=%h vld=%b busy=%b cnt=%0d, required %h 1 0 0", word, word_vld, busy, bit_cnt, sb_q[0]);
    end else $display("frame basic: word=%h", word);
  endtask

  task automatic test_overrun();
    logic [3:0] bits;
    bits = 4'b0010;
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    checks++;
    if (overrun !== 1'b1 || word_vld !== 1'b1 || word !== sb_q[0]) begin
      errors++; $display("FAIL overrun_set: ovr=%b vld=%b word=%h, required 1 1 %h", overrun, word_vld, word, sb_q[0]);
    end else $display("frame dropped: overrun set, word=%h kept", word);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b0 || word !== sb_q[0]) begin
      errors++; $display("FAIL overrun_clr: ovr=%b word=%h, required 0 %h", overrun, word, sb_q[0]);
    end
    // Clear and a fresh overrun in the same cycle: the set must win.
    pulse_start();
    for (int i = 0; i < 3; i++) send_bit(bits[i]);
    clr_err = 1'b1;
    send_bit(bits[3]);
    clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set_wins: ovr=%b, required 1", overrun);
    end
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    word_rdy = 1'b1;
    send_bit(1'b1);
    word_rdy = 1'b0;
    exp_w = sb_q.pop_front();
    $display("consume b2b: word=%h accepted on completion cycle", exp_w);
    sb_q.push_back(4'hF);
    checks++;
    if (word_vld !== 1'b1 || word !== sb_q[0] || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b: vld=%b word=%h ovr=%b, required 1 %h 0", word_vld, word, overrun, sb_q[0]);
    end
    consume("b2b_F");
    word_rdy = 1'b1; step(); word_rdy = 1'b0;
    checks++;
    if (word_vld !== 1'b0) begin
      errors++; $display("FAIL rdy_when_empty: vld=%b, required 0", word_vld);
    end
  endtask

  task automatic test_restart();
    logic [3:0] bits;
    pulse_start();
    send_bit(1'b1); send_bit(1'b1);
    checks++;
    if (bit_cnt !== 3'd2) begin
      errors++; $display("FAIL restart_pre: cnt=%0d, required 2", bit_cnt);
    end
    start = 1'b1; sin = 1'b1; sin_vld = 1'b1;
    step();
    start = 1'b0; sin_vld = 1'b0;
    checks++;
    if (bit_cnt !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_cnt: cnt=%0d busy=%b, required 0 1", bit_cnt, busy);
    end
    bits = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i]);
      checks++;
      if (bit_cnt > 3'd4) begin
        errors++; $display("FAIL cnt_bound: cnt=%0d, required <= 4", bit_cnt);
      end
    end
    sb_q.push_back(4'h8);
    consume("restart_8");
    // Long sin_vld gap mid-frame must not disturb the result.
    pulse_start();
    send_bit(1'b1); send_bit(1'b0);
    repeat (5) step();
    checks++;
    if (bit_cnt !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL stall: cnt=%0d busy=%b, required 2 1", bit_cnt, busy);
    end
    send_bit(1'b1); send_bit(1'b0);
    sb_q.push_back(4'h5);
    consume("stall_5");
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b1010;
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    checks++;
    if (word_vld !== 1'b1 || word !== 4'hA) begin
      errors++; $display("FAIL pre_reset_word: vld=%b word=%h, required 1 a", word_vld, word);
    end
    pulse_start();
    send_bit(1'b1); send_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({word, word_vld, busy, bit_cnt, overrun, par_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: word=%h vld=%b busy=%b cnt=%0d ovr=%b perr=%b, required all 0",
               word, word_vld, busy, bit_cnt, overrun, par_err);
    end else $display("async reset mid-frame: outputs cleared");
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    bits = 4'b0001;
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    sb_q.push_back(4'h1);
    consume("after_reset_1");
  endtask

`ifdef SIPO_PARITY_CHK_EN
  task automatic test_parity();
    logic [3:0] bits;
    bits = 4'b1101;
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    checks++;
    if (busy !== 1'b1 || word_vld !== 1'b0 || bit_cnt !== 3'd4) begin
      errors++; $display("FAIL par_wait: busy=%b vld=%b cnt=%0d, required 1 0 4", busy, word_vld, bit_cnt);
    end
    send_bit(1'b1);
    sb_q.push_back(4'hD);
    consume("parity_ok");
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    send_bit(1'b0);
    checks++;
    if (word_vld !== 1'b0 || par_err !== 1'b1 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL parity_bad: vld=%b perr=%b ovr=%b busy=%b, required 0 1 0 0", word_vld, par_err, overrun, busy);
    end else $display("frame parity error flagged");
    clr_err = 1'b1; step(); clr_err = 1'b0;
    checks++;
    if (par_err !== 1'b0) begin
      errors++; $display("FAIL parity_clr: perr=%b, required 0", par_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_restart();
    test_async_reset();
`ifdef SIPO_PARITY_CHK_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
